// File: rtl/nora_spi_master.sv
// ----------------------------------------------------------------------------
// nora_spi_master
//   CPU-visible SPI master (mode 0, MSB first) behind the NORA I/O decoder.
//   Bytes written to DATA enter a TX FIFO and are shifted out on spi_sck /
//   spi_mosi. The bytes received on spi_miso are collected in an RX FIFO that
//   the CPU reads back through DATA.
//
//   Optional feature macro: SPI_LOOPBACK_EN
//     When defined, CTRL[6] (LOOP) is implemented. While LOOP=1 the shifter
//     samples its own spi_mosi and every chip select is held inactive.
//
// Parameters
//   FIFO_DEPTH : TX and RX FIFO depth in bytes (power of 2, 2..8)
//   NUM_CS     : number of active-low chip selects, spi_csn[0] = SPI flash
//
// Ports
//   clk      : system clock, rising edge
//   resetn   : asynchronous active-low reset
//   reg_sel  : 0=CTRL, 1=STAT, 2=DATA, 3=reserved
//   reg_wr   : one-cycle write strobe
//   reg_rd   : one-cycle read strobe (pops RX when reg_sel=DATA)
//   wdata    : write data
//   rdata    : read data, combinational from reg_sel and current state
//   spi_sck  : serial clock, idle low
//   spi_mosi : serial data out
//   spi_miso : serial data in
//   spi_csn  : active-low chip selects
// ----------------------------------------------------------------------------
module nora_spi_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        reg_sel,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_csn
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_STAT = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;

`ifdef SPI_LOOPBACK_EN
  localparam logic [7:0] CTRL_MASK = 8'h7F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h3F;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // --------------------------------------------------------------------------
  // Register file decode
  // --------------------------------------------------------------------------
  logic       busy;
  logic       ctrl_wr;
  logic       stat_wr;
  logic       data_wr;
  logic       data_rd;
  logic [7:0] ctrl_reg;
  logic [2:0] target;
  logic [2:0] speed;
  logic       loop;
  logic       ovf_reg;

  assign ctrl_wr = reg_wr && (reg_sel == SEL_CTRL) && !busy;
  assign stat_wr = reg_wr && (reg_sel == SEL_STAT);
  assign data_wr = reg_wr && (reg_sel == SEL_DATA);
  assign data_rd = reg_rd && (reg_sel == SEL_DATA);

  assign target = ctrl_reg[2:0];
  assign speed  = ctrl_reg[5:3];

`ifdef SPI_LOOPBACK_EN
  assign loop = ctrl_reg[6];
`else
  assign loop = 1'b0;
`endif

  // The unimplemented bits are masked at write time so a readback is exact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_reg <= 8'h00;
    end else if (ctrl_wr) begin
      ctrl_reg <= wdata & CTRL_MASK;
    end
  end

  // Chip selects follow TARGET directly, so CS stays low across back-to-back
  // bytes; loopback forces every select inactive.
  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_csn
      localparam logic [2:0] CS_CODE = 3'(gi + 1);
      assign spi_csn[gi] = !((target == CS_CODE) && !loop);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr;
  logic [PTR_W-1:0] tx_rd_ptr;
  logic [CNT_W-1:0] tx_count;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_push;
  logic             tx_pop;
  logic [7:0]       tx_head;

  state_t state_reg;
  state_t state_next;

  assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = data_wr && !tx_full;
  // LOAD is only entered with a non-empty TX FIFO.
  assign tx_pop   = (state_reg == ST_LOAD);
  assign tx_head  = tx_mem[tx_rd_ptr];

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly clog2(FIFO_DEPTH) wide, so they wrap at FIFO_DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr;
  logic [PTR_W-1:0] rx_rd_ptr;
  logic [CNT_W-1:0] rx_count;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_pop;
  logic             rx_push_req;
  logic             rx_push;
  logic [7:0]       rx_shreg;
  logic [3:0]       rx_level;

  assign rx_full     = (rx_count == CNT_W'(FIFO_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_pop      = data_rd && !rx_empty;
  assign rx_push_req = (state_reg == ST_DONE);
  // A pop in the same cycle frees the slot, so full+pop+push is accepted.
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_level    = 4'(rx_count);

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_shreg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky overflow; a new overflow event beats a clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_reg <= 1'b0;
    end else if ((data_wr && tx_full) || (rx_push_req && rx_full && !rx_pop)) begin
      ovf_reg <= 1'b1;
    end else if (stat_wr) begin
      ovf_reg <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Shift engine
  // --------------------------------------------------------------------------
  logic [6:0] div_reg;
  logic [6:0] div_next;
  logic [3:0] edge_reg;
  logic [3:0] edge_next;
  logic       sck_reg;
  logic       sck_next;
  logic [7:0] tx_shreg;
  logic [7:0] tx_shreg_next;
  logic [7:0] rx_shreg_next;
  logic [6:0] div_last;
  logic       sample_bit;

  // Half-period of 2^SPEED cycles: the divider counts 0..2^SPEED-1.
  assign div_last   = 7'((8'd1 << speed) - 8'd1);
  // MOSI is the top bit of the TX shifter, so it changes only on LOAD or SCK fall.
  assign spi_mosi   = tx_shreg[7];
  assign spi_sck    = sck_reg;
  assign sample_bit = loop ? tx_shreg[7] : spi_miso;
  assign busy       = (state_reg != ST_IDLE) || !tx_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
      edge_reg  <= '0;
      sck_reg   <= 1'b0;
      tx_shreg  <= 8'h00;
      rx_shreg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      edge_reg  <= edge_next;
      sck_reg   <= sck_next;
      tx_shreg  <= tx_shreg_next;
      rx_shreg  <= rx_shreg_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    edge_next     = edge_reg;
    sck_next      = sck_reg;
    tx_shreg_next = tx_shreg;
    rx_shreg_next = rx_shreg;
    case (state_reg)
      ST_IDLE: begin
        if (!tx_empty) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        tx_shreg_next = tx_head;
        rx_shreg_next = 8'h00;
        div_next      = '0;
        edge_next     = '0;
        sck_next      = 1'b0;
        state_next    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_reg == div_last) begin
          div_next  = '0;
          edge_next = edge_reg + 4'd1;
          if (!edge_reg[0]) begin
            // Odd (1st, 3rd, ...) edge: SCK rises, sample the input bit.
            sck_next      = 1'b1;
            rx_shreg_next = {rx_shreg[6:0], sample_bit};
          end else begin
            // Even edge: SCK falls, present the next bit.
            sck_next      = 1'b0;
            tx_shreg_next = {tx_shreg[6:0], 1'b0};
            if (edge_reg == 4'd15) state_next = ST_DONE;
          end
        end else begin
          div_next = div_reg + 7'd1;
        end
      end
      ST_DONE: begin
        state_next = tx_empty ? ST_IDLE : ST_LOAD;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      SEL_CTRL: rdata = ctrl_reg;
      SEL_STAT: rdata = {busy, tx_full, rx_empty, ovf_reg, rx_level};
      SEL_DATA: rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      default:  rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_nora_spi_master.sv
`timescale 1ns/1ps
module tb_nora_spi_master;

  localparam int DEPTH = 4;
  localparam int NCS   = 2;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [1:0]     reg_sel = 2'd0;
  logic           reg_wr = 1'b0;
  logic           reg_rd = 1'b0;
  logic [7:0]     wdata = 8'h00;
  logic [7:0]     rdata;
  logic           spi_sck;
  logic           spi_mosi;
  logic           spi_miso;
  logic [NCS-1:0] spi_csn;

  always #5 clk = ~clk;

  nora_spi_master #(.FIFO_DEPTH(DEPTH), .NUM_CS(NCS)) dut (
    .clk(clk), .resetn(resetn), .reg_sel(reg_sel), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .wdata(wdata), .rdata(rdata), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_csn(spi_csn)
  );

  int tests_run = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference model: what an SPI mode-0 slave sees, and what the CPU should read.
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  int         m_tx_level = 0;
  bit         tx_drop = 0;
  int         rx_drop_cnt = 0;
  int         rx_drop_base = 0;
  bit         loop_mode = 0;
  int         miso_mode = 0;   // 0 random byte, 1 ~mosi, 2 const 0, 3 const 1
  logic [7:0] cur_miso = 8'h00;

  // Slave-side pin monitor
  logic [2:0] bit_cnt = 3'd0;
  logic [7:0] mon_mosi = 8'h00;
  logic [7:0] mon_miso = 8'h00;
  int         sck_rises = 0;
  time        rise_t [1024];

  always_comb begin
    case (miso_mode)
      0:       spi_miso = cur_miso[3'd7 - bit_cnt];
      1:       spi_miso = ~spi_mosi;
      2:       spi_miso = 1'b0;
      default: spi_miso = 1'b1;
    endcase
  end

  always @(posedge spi_sck or negedge resetn) begin
    if (!resetn) begin
      bit_cnt = 3'd0;
    end else begin
      logic [7:0] rx_byte;
      mon_mosi = {mon_mosi[6:0], spi_mosi};
      mon_miso = {mon_miso[6:0], spi_miso};
      rise_t[sck_rises % 1024] = $time;
      sck_rises++;
      if (bit_cnt == 3'd7) begin
        bit_cnt = 3'd0;
        if (exp_mosi.size() == 0) begin
          tests_run++;
          fails++;
          $display("[TB] FAIL mosi_byte: got 0x%0h with no byte expected", mon_mosi);
        end else begin
          check("mosi_byte", mon_mosi, exp_mosi.pop_front());
        end
        rx_byte = loop_mode ? mon_mosi : mon_miso;
        if (exp_rx.size() < DEPTH) exp_rx.push_back(rx_byte);
        else rx_drop_cnt++;
        cur_miso = 8'($urandom);
      end else begin
        bit_cnt = bit_cnt + 3'd1;
      end
    end
  end

  // ---------------- bus helpers (enter/leave at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [7:0] d);
    reg_sel = sel; wdata = d; reg_wr = 1'b1;
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [7:0] d);
    reg_sel = sel; reg_rd = 1'b1;
    #2 d = rdata;
    @(posedge clk); #1;
    reg_rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] sel, output logic [7:0] d);
    reg_sel = sel;
    #1 d = rdata;
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (m_tx_level >= DEPTH) begin
      tx_drop = 1;
    end else begin
      exp_mosi.push_back(b);
      m_tx_level++;
    end
    bus_write(2'd2, b);
  endtask

  task automatic clear_ovf();
    bus_write(2'd1, 8'h00);
    tx_drop = 0;
    rx_drop_base = rx_drop_cnt;
  endtask

  function automatic logic [7:0] stat_exp(input bit bsy, input bit txf);
    bit ovf;
    ovf = tx_drop || (rx_drop_cnt != rx_drop_base);
    return {bsy, txf, exp_rx.size() == 0, ovf, 4'(exp_rx.size())};
  endfunction

  task automatic wait_idle(input int max_cycles);
    logic [7:0] s;
    peek(2'd1, s);
    for (int i = 0; i < max_cycles && s[7]; i++) begin
      tick(1);
      peek(2'd1, s);
    end
    check("wait_idle_busy", s[7], 1'b0);
    m_tx_level = 0;
  endtask

  task automatic read_rx(input int n);
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
      bus_read(2'd2, d);
      check("rx_data", d, e);
    end
  endtask

  function automatic logic [NCS-1:0] csn_exp(input int tgt);
    logic [NCS-1:0] c;
    c = '1;
    if (tgt >= 1 && tgt <= NCS) c[tgt-1] = 1'b0;
    return c;
  endfunction

  initial begin
    logic [7:0] d;
    int start;
    int lat;
    time pmin, pmax, p;

    // 1. reset
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
    peek(2'd1, d); check("reset_stat", d, 8'h20);
    peek(2'd0, d); check("reset_ctrl", d, 8'h00);
    check("reset_csn", spi_csn, {NCS{1'b1}});
    check("reset_sck", spi_sck, 1'b0);
    check("reset_mosi", spi_mosi, 1'b0);

    // 2. three bytes with miso = ~mosi
    miso_mode = 1;
    bus_write(2'd0, 8'h21);
    peek(2'd0, d); check("ctrl_readback", d, 8'h21);
    check("csn_flash", spi_csn, csn_exp(1));
    push_byte(8'h03); push_byte(8'h12); push_byte(8'h34);
    peek(2'd1, d); check("busy_set", d[7], 1'b1);
    wait_idle(5000);
    peek(2'd1, d); check("stat_level3", d, stat_exp(0, 0));
    read_rx(3);
    peek(2'd1, d); check("stat_after_reads", d, 8'h20);

    // 3. SPEED=0 timing
    miso_mode = 0;
    bus_write(2'd0, 8'h01);
    start = sck_rises;
    push_byte(8'hA5);
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      tick(1);
      peek(2'd1, d);
      if (d[3:0] != 4'd0) lat = c;
    end
    check("rx_push_latency", lat, 19);
    wait_idle(200);
    check("sck_rise_count", sck_rises - start, 8);
    pmin = 1000000; pmax = 0;
    for (int k = 1; k < 8; k++) begin
      p = rise_t[(start + k) % 1024] - rise_t[(start + k - 1) % 1024];
      if (p < pmin) pmin = p;
      if (p > pmax) pmax = p;
    end
    check("sck_period_min_ns", 32'(pmin), 20);
    check("sck_period_max_ns", 32'(pmax), 20);
    read_rx(1);

    // 4. overflow, SPEED=7, miso=0
    miso_mode = 2;
    bus_write(2'd0, 8'h39);
    push_byte(8'($urandom));
    tick(20);
    m_tx_level--;              // first byte now sits in the shifter
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    peek(2'd1, d); check("stat_txfull", d, stat_exp(1, 1));
    push_byte(8'($urandom));   // dropped
    peek(2'd1, d); check("stat_tx_ovf", d, stat_exp(1, 1));
    clear_ovf();
    peek(2'd1, d); check("stat_ovf_cleared", d, stat_exp(1, 1));
    wait_idle(20000);
    peek(2'd1, d); check("stat_rx_ovf", d, stat_exp(0, 0));
    clear_ovf();
    peek(2'd1, d); check("stat_full_no_ovf", d, stat_exp(0, 0));
    read_rx(4);
    bus_read(2'd2, d); check("empty_read", d, 8'h00);
    peek(2'd1, d); check("stat_empty", d, 8'h20);

    // 5. CTRL locked while busy, then async reset mid-byte
    miso_mode = 0;
    bus_write(2'd0, 8'h21);
    push_byte(8'h96);
    tick(60);
    bus_write(2'd0, 8'h00);
    peek(2'd0, d); check("ctrl_locked", d, 8'h21);
    tick(20);
    resetn = 1'b0;
    exp_mosi.delete(); exp_rx.delete();
    m_tx_level = 0; tx_drop = 0; rx_drop_base = rx_drop_cnt;
    #1;
    check("rst_mid_sck", spi_sck, 1'b0);
    check("rst_mid_csn", spi_csn, {NCS{1'b1}});
    peek(2'd1, d); check("rst_mid_stat", d, 8'h20);
    tick(2);
    resetn = 1'b1;
    start = sck_rises;
    tick(600);
    peek(2'd1, d); check("post_rst_stat", d, 8'h20);
    check("post_rst_no_sck", sck_rises - start, 0);

    // 6. loopback
`ifdef SPI_LOOPBACK_EN
    bus_write(2'd0, 8'h61);
    peek(2'd0, d); check("loop_ctrl", d, 8'h61);
    loop_mode = 1; miso_mode = 3;
    push_byte(8'h5A);
    tick(30);
    check("loop_csn", spi_csn, {NCS{1'b1}});
    wait_idle(2000);
    read_rx(1);
    loop_mode = 0;
`else
    bus_write(2'd0, 8'h21);
    bus_write(2'd0, 8'h61);
    peek(2'd0, d); check("noloop_ctrl", d, 8'h21);
`endif

    // randomized bursts
    for (int it = 0; it < 8; it++) begin
      int spd, tgt, n;
      logic [7:0] c;
      spd = $urandom_range(0, 2);
      tgt = $urandom_range(0, 3);
      n = $urandom_range(1, DEPTH);
      miso_mode = $urandom_range(0, 1);
      c = 8'((spd << 3) | tgt);
      bus_write(2'd0, c);
      peek(2'd0, d); check("rand_ctrl", d, c);
      check("rand_csn", spi_csn, csn_exp(tgt));
      for (int b = 0; b < n; b++) push_byte(8'($urandom));
      wait_idle(3000);
      peek(2'd1, d); check("rand_stat", d, stat_exp(0, 0));
      read_rx(n);
    end

    check("mosi_queue_drained", exp_mosi.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
